// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial shifter (din/load/ready in, dn/dn_valid/busy/done out); define SERIAL_PARITY_EN to append an even-parity bit
module serial_bit_source #(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             dn,
  output logic             dn_valid,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [1:0] {
    IDLE,
`ifdef SERIAL_PARITY_EN
    PARITY,
`endif
    SHIFT
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic dn_q, dn_d, dv_q, dv_d, busy_q, busy_d, done_q, done_d;
  logic last, accept;
`ifdef SERIAL_PARITY_EN
  logic par_q, par_d;
  assign last = state_q == PARITY;
`else
  assign last = state_q == SHIFT && idx_q == LAST;
`endif
  assign ready = state_q == IDLE || last;
  assign accept = load && ready;
  assign dn = dn_q;
  assign dn_valid = dv_q;
  assign busy = busy_q;
  assign done = done_q;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST != 0 ? w[WIDTH-1] : w[0];
  endfunction
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    dn_d = 1'b0;
    dv_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_d = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      sr_d = din;
      idx_d = '0;
      dn_d = head(din);
      dv_d = 1'b1;
      busy_d = 1'b1;
`ifdef SERIAL_PARITY_EN
      par_d = ^din;
`endif
    end else if (state_q == SHIFT && idx_q != LAST) begin
      sr_d = MSB_FIRST != 0 ? sr_q << 1 : sr_q >> 1;
      idx_d = idx_q + 1'b1;
      dn_d = head(sr_d);
      dv_d = 1'b1;
      busy_d = 1'b1;
`ifndef SERIAL_PARITY_EN
      done_d = idx_d == LAST;
`endif
`ifdef SERIAL_PARITY_EN
    end else if (state_q == SHIFT) begin
      state_d = PARITY;
      idx_d = idx_q + 1'b1;
      dn_d = par_q;
      dv_d = 1'b1;
      busy_d = 1'b1;
      done_d = 1'b1;
`endif
    end else begin
      state_d = IDLE;
      sr_d = '0;
      idx_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      dn_q <= 1'b0;
      dv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      dn_q <= dn_d;
      dv_q <= dv_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef SERIAL_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: checks MSB-first and LSB-first instances against a bit-queue reference model
module tb_serial_bit_source;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [W-1:0] din = '0;
  logic rdy_m, dn_m, dv_m, busy_m, done_m;
  logic rdy_l, dn_l, dv_l, busy_l, done_l;
  logic [4:0] om, ol;
  logic qm[$];
  logic ql[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(rdy_m),
    .dn(dn_m), .dn_valid(dv_m), .busy(busy_m), .done(done_m));
  serial_bit_source #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(rdy_l),
    .dn(dn_l), .dn_valid(dv_l), .busy(busy_l), .done(done_l));
  assign om = {rdy_m, busy_m, dv_m, dn_m, done_m};
  assign ol = {rdy_l, busy_l, dv_l, dn_l, done_l};
  function automatic logic [4:0] expv(input int n, input logic b);
    return {n <= 1, n > 0, n > 0, n > 0 && b, n == 1};
  endfunction
  function automatic logic [9:0] exp_all();
    return {expv(qm.size(), qm.size() > 0 ? qm[0] : 1'b0),
            expv(ql.size(), ql.size() > 0 ? ql[0] : 1'b0)};
  endfunction
  task automatic push(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back(d[W-1-i]);
      ql.push_back(d[i]);
    end
`ifdef SERIAL_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask
  task automatic cyc(input logic r, input logic l, input logic [W-1:0] d);
    logic can;
    rst = r;
    load = l;
    din = d;
    @(posedge clk);
    can = qm.size() <= 1;
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (l && can) push(d);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    cyc(1, 1, 8'hAA);
    cyc(1, 0, 8'h00);
    tests++;
    if ({om, ol} !== 10'b10000_10000) begin
      fails++;
      $display("FAIL reset: got %b expected %b", {om, ol}, 10'b10000_10000);
    end
    cyc(0, 0, 8'h00);
    tests++;
    if ({om, ol} !== exp_all()) begin
      fails++;
      $display("FAIL reset_idle: got %b expected %b", {om, ol}, exp_all());
    end
  endtask
  task automatic test_basic();
    logic [8:0] v = '0;
    int dc = 0;
    cyc(0, 1, 8'hE3);
    for (int i = 0; i < 11; i++) begin
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL basic cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
      if (dv_m) v = {v[7:0], dn_m};
      dc += int'(done_m);
      cyc(0, 0, 8'h00);
    end
`ifdef SERIAL_PARITY_EN
    tests++;
    if (v !== 9'h1C7) begin
      fails++;
      $display("FAIL basic_stream: got %h expected %h", v, 9'h1C7);
    end
`else
    tests++;
    if (v[7:0] !== 8'hE3) begin
      fails++;
      $display("FAIL basic_stream: got %h expected %h", v[7:0], 8'hE3);
    end
`endif
    tests++;
    if (dc !== 1) begin
      fails++;
      $display("FAIL basic_done: got %0d expected 1", dc);
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] v = '0;
    int dc = 0, vc = 0;
    cyc(0, 1, 8'hF0);
    for (int i = 0; i < 18; i++) begin
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL b2b cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
      if (dv_m) begin
        v = {v[14:0], dn_m};
        vc++;
      end
      dc += int'(done_m);
      if (i < 7) cyc(0, 1, 8'hF0);
      else if (i == 7) cyc(0, 1, 8'h0F);
      else cyc(0, 0, 8'h00);
    end
`ifndef SERIAL_PARITY_EN
    tests++;
    if ({v, vc[4:0], dc[1:0]} !== {16'hF00F, 5'd16, 2'd2}) begin
      fails++;
      $display("FAIL b2b_stream: got %h/%0d/%0d expected f00f/16/2", v, vc, dc);
    end
`endif
  endtask
  task automatic test_reset_mid();
    logic [7:0] vm = '0, vl = '0;
    cyc(0, 1, 8'hE3);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    tests++;
    if ({om, ol} !== 10'b10000_10000) begin
      fails++;
      $display("FAIL rst_mid: got %b expected %b", {om, ol}, 10'b10000_10000);
    end
    cyc(0, 1, 8'h80);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL rst_mid cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
      vm = {vm[6:0], dn_m};
      vl = {vl[6:0], dn_l};
      cyc(0, 0, 8'h00);
    end
    tests++;
    if ({vm, vl} !== {8'h80, 8'h01}) begin
      fails++;
      $display("FAIL rst_mid_stream: got %h %h expected 80 01", vm, vl);
    end
    cyc(0, 0, 8'h00);
  endtask
  task automatic test_ignore_load();
    logic [7:0] v = '0;
    cyc(0, 1, 8'hE3);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL ignore cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
      v = {v[6:0], dn_m};
      cyc(0, i == 1, i == 1 ? 8'hFF : 8'h00);
    end
    cyc(0, 0, 8'h00);
    tests++;
    if ({v, om} !== {8'hE3, 5'b10000}) begin
      fails++;
      $display("FAIL ignore_stream: got %h %b expected e3 10000", v, om);
    end
  endtask
  task automatic test_lsb();
    logic [7:0] vl = '0, vm = '0;
    cyc(0, 1, 8'h01);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL lsb cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
      vl = {vl[6:0], dn_l};
      vm = {vm[6:0], dn_m};
      cyc(0, 0, 8'h00);
    end
    tests++;
    if ({vl, vm} !== {8'h80, 8'h01}) begin
      fails++;
      $display("FAIL lsb_stream: got %h %h expected 80 01", vl, vm);
    end
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, W'($urandom));
      tests++;
      if ({om, ol} !== exp_all()) begin
        fails++;
        $display("FAIL random cycle %0d: got %b expected %b", i, {om, ol}, exp_all());
      end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_ignore_load();
    test_lsb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_bit_source.md
SERIAL_BIT_SOURCE -- requirements
Module: serial_bit_source

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port din, input, WIDTH, parallel word to serialize.
REQ-006 SHALL have port load, input, 1, request to accept din.
REQ-007 SHALL have port ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port dn, output, 1, serial bit stream to the downstream sequence detector.
REQ-009 SHALL have port dn_valid, output, 1, dn carries a real bit this cycle.
REQ-010 SHALL have port busy, output, 1, a word is being shifted out.
REQ-011 SHALL have port done, output, 1, one-cycle pulse coincident with the final serial bit of a word.

Function
REQ-012 SHALL accept a word on a rising edge where load=1 and ready=1, capturing din into an internal shift register.
REQ-013 SHALL ignore load when ready=0; din changes after acceptance SHALL not affect the word in flight.
REQ-014 SHALL implement states IDLE, SHIFT and PARITY (PARITY exists only with PARITY_EN).
REQ-015 IDLE: ready=1, dn_valid=0, busy=0; on accept -> SHIFT with bit index 0.
REQ-016 SHIFT: dn_valid=1, busy=1, dn = current bit; index advances by one per cycle; after bit WIDTH-1 -> PARITY if PARITY_EN, else IDLE.
REQ-017 Latency: the first bit SHALL appear on dn in the cycle immediately after the accepting edge; bits SHALL be contiguous, one per cycle, no gaps.
REQ-018 ready SHALL also be 1 during the final serial cycle of a word (last data bit, or parity bit with PARITY_EN); an accept there SHALL start the next word's bit 0 in the following cycle with no idle gap.
REQ-019 If no accept occurs in the final serial cycle, the block SHALL return to IDLE.
REQ-020 done SHALL be 1 for exactly one cycle per word, in the final serial cycle.
REQ-021 dn SHALL be 0 whenever dn_valid=0.
REQ-022 dn, dn_valid, busy and done SHALL be driven from registers, not combinationally from load or din.
REQ-023 The bit index counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL enter IDLE; dn=0, dn_valid=0, busy=0, done=0, ready=1, and the shift register and bit index SHALL clear to 0.
REQ-025 rst SHALL take priority over load; a word accepted or in flight when rst is sampled SHALL be discarded, and its remaining bits SHALL never be sent.
REQ-026 The first word accepted after reset SHALL start from bit 0.

Configuration
REQ-027 Macro SERIAL_PARITY_EN SHALL compile in the PARITY state.
REQ-028 With SERIAL_PARITY_EN defined, one even-parity bit (XOR of the accepted word) SHALL follow the data bits, with dn_valid=1, making WIDTH+1 serial cycles per word.
REQ-029 With SERIAL_PARITY_EN undefined, exactly WIDTH serial cycles per word SHALL be sent, and no parity logic SHALL exist.

Verification
REQ-030 Without parity, MSB_FIRST=1: rst, then load din=8'hE3 -> dn=1,1,1,0,0,0,1,1 on 8 consecutive cycles starting the cycle after accept; dn_valid high for 8 cycles; done only on the 8th cycle.
REQ-031 With SERIAL_PARITY_EN: load 8'hE3 -> the 8 data bits above, then a 9th bit dn=1 (five ones); done on the 9th cycle.
REQ-032 Without parity: load held high with 8'hF0, then 8'h0F presented in the final cycle -> 16 contiguous valid bits 1111000000001111, no gap, two done pulses.
REQ-033 Assert rst after 3 bits of 8'hE3 -> next cycle dn_valid=0, ready=1, busy=0; a new load of 8'h80 sends 1 then seven 0s.
REQ-034 Pulse load with 8'hFF during the 2nd bit of 8'hE3 -> ignored; output stays 11100011, and IDLE follows.
REQ-035 MSB_FIRST=0: load 8'h01 -> dn=1, then seven 0s.
